// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode type and pointer helper for the stream multiplexer.
package stream_mux_pkg;
    typedef enum logic {MODE_MANUAL = 1'b0, MODE_RR = 1'b1} mux_mode_e;
    function automatic int next_ptr(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, first set req bit at or after start, wrapping modulo N_CH.
module rr_pick #(
    parameter int N_CH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    function automatic logic [SEL_W-1:0] wrap(input int s);
        return SEL_W'((s >= N_CH) ? s - N_CH : s);
    endfunction
    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req[wrap(int'(start) + k)]) begin
                found = 1'b1;
                idx = wrap(int'(start) + k);
            end
        end
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with manual or round-robin select
// and a registered one-deep output stage.
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);
    import stream_mux_pkg::*;
    localparam int NP = 1 << SEL_W;
    // Zero-padded so an out-of-range manual select simply finds no valid.
    logic [NP-1:0]    valid_pad;
    logic [SEL_W-1:0] rr_ptr, rr_idx, grant;
    logic             rr_found, rr_mode, grant_ok, load_en, xfer;
    assign valid_pad = NP'(in_valid);
    assign rr_mode = mode == MODE_RR;
    rr_pick #(.N_CH(N_CH)) u_pick (
        .req(in_valid),
        .start(rr_ptr),
        .found(rr_found),
        .idx(rr_idx)
    );
    always_comb begin
        grant = rr_mode ? rr_idx : sel;
        grant_ok = !rst && (rr_mode ? rr_found : valid_pad[sel]);
        load_en = !out_valid || out_ready;
        xfer = grant_ok && load_en;
        in_ready = xfer ? N_CH'(1) << grant : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_ch <= '0;
            rr_ptr <= '0;
        end else begin
            if (load_en) out_valid <= grant_ok;
            if (xfer) begin
                out_data <= in_data[int'(grant) * WIDTH +: WIDTH];
                out_ch <= grant;
                if (rr_mode) rr_ptr <= SEL_W'(next_ptr(int'(grant), N_CH));
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and randomized checks of stream_mux_rr at N_CH = 4, 8 and 3.
module tb_stream_mux_rr;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, mode, out_ready;
    logic [1:0] sel4;  logic [3:0] v4, r4;  logic [31:0] d4;  logic ov4;  logic [7:0] od4;  logic [1:0] oc4;
    logic [2:0] sel8;  logic [7:0] v8, r8;  logic [63:0] d8;  logic ov8;  logic [7:0] od8;  logic [2:0] oc8;
    logic [1:0] sel3;  logic [2:0] v3, r3;  logic [23:0] d3;  logic ov3;  logic [7:0] od3;  logic [1:0] oc3;
    int checks = 0;
    int fails = 0;

    stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .mode(mode), .sel(sel4), .in_valid(v4),
        .in_data(d4), .in_ready(r4), .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(out_ready));
    stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut8 (.clk(clk), .rst(rst), .mode(mode), .sel(sel8), .in_valid(v8),
        .in_data(d8), .in_ready(r8), .out_valid(ov8), .out_data(od8), .out_ch(oc8), .out_ready(out_ready));
    stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .mode(mode), .sel(sel3), .in_valid(v3),
        .in_data(d3), .in_ready(r3), .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(out_ready));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mode = 1'b1; out_ready = 1'b1;
        v4 = '1; v8 = '1; v3 = '1;
        #1;
        checks++; if (r4 !== 4'b0) begin fails++; $display("FAIL reset_in_ready4: got %b expected 0000", r4); end
        checks++; if (r8 !== 8'b0) begin fails++; $display("FAIL reset_in_ready8: got %b expected 00000000", r8); end
        checks++; if (r3 !== 3'b0) begin fails++; $display("FAIL reset_in_ready3: got %b expected 000", r3); end
        tick;
        tick;
        checks++; if (ov4 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", ov4); end
        checks++; if (od4 !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h expected 00", od4); end
        checks++; if (oc4 !== 2'd0) begin fails++; $display("FAIL reset_out_ch: got %0d expected 0", oc4); end
        checks++; if (r4 !== 4'b0) begin fails++; $display("FAIL reset_in_ready_held: got %b expected 0000", r4); end
        checks++; if (ov3 !== 1'b0 || ov8 !== 1'b0) begin fails++; $display("FAIL reset_out_valid_38: got %b%b expected 00", ov3, ov8); end
        rst = 1'b0; v4 = '0; v8 = '0; v3 = '0;
        tick;
        tick;
        checks++; if (ov4 !== 1'b0) begin fails++; $display("FAIL idle_out_valid: got %b expected 0", ov4); end
    endtask

    task automatic test_manual;
        mode = 1'b0; out_ready = 1'b1;
        sel4 = 2'd2; v4 = 4'hf; d4 = 32'h03020100;
        sel8 = 3'd3; v8 = 8'hff; d8 = 64'h7766554433221100;
        #1;
        checks++; if (r4 !== 4'b0100) begin fails++; $display("FAIL manual_in_ready: got %b expected 0100", r4); end
        tick;
        checks++; if (ov4 !== 1'b1) begin fails++; $display("FAIL manual_out_valid: got %b expected 1", ov4); end
        checks++; if (od4 !== 8'h02) begin fails++; $display("FAIL manual_out_data: got %h expected 02", od4); end
        checks++; if (oc4 !== 2'd2) begin fails++; $display("FAIL manual_out_ch: got %0d expected 2", oc4); end
        checks++; if (oc8 !== 3'd3 || od8 !== 8'h33) begin fails++; $display("FAIL manual8_load: got ch %0d data %h expected ch 3 data 33", oc8, od8); end
        sel8 = 3'd5; v8 = 8'hdf;
        sel3 = 2'd3; v3 = 3'b111;
        #1;
        checks++; if (r8 !== 8'b0) begin fails++; $display("FAIL manual8_invalid_ready: got %b expected 00000000", r8); end
        checks++; if (r3 !== 3'b0) begin fails++; $display("FAIL manual3_oob_ready: got %b expected 000", r3); end
        tick;
        checks++; if (ov8 !== 1'b0) begin fails++; $display("FAIL manual8_drain: got out_valid %b expected 0", ov8); end
        checks++; if (oc8 !== 3'd3 || od8 !== 8'h33) begin fails++; $display("FAIL manual8_hold: got ch %0d data %h expected ch 3 data 33", oc8, od8); end
        checks++; if (ov3 !== 1'b0) begin fails++; $display("FAIL manual3_oob_valid: got %b expected 0", ov3); end
        v8 = '0; v3 = '0;
    endtask

    task automatic test_rr_fair;
        int seq[4] = '{3, 1, 3, 1};
        pulse_reset;
        mode = 1'b1; out_ready = 1'b1; v4 = 4'hf; d4 = 32'h03020100;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (ov4 !== 1'b1 || oc4 !== 2'(i % 4) || od4 !== 8'(i % 4))
                begin fails++; $display("FAIL rr_all[%0d]: got v %b ch %0d data %h expected ch %0d", i, ov4, oc4, od4, i % 4); end
        end
        v4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (oc4 !== 2'(seq[i]) || od4 !== 8'(seq[i]))
                begin fails++; $display("FAIL rr_sparse[%0d]: got ch %0d data %h expected %0d", i, oc4, od4, seq[i]); end
        end
    endtask

    task automatic test_backpressure;
        v4 = 4'hf; d4 = 32'hd3c2b1a0;
        tick;
        checks++; if (oc4 !== 2'd2 || od4 !== 8'hc2) begin fails++; $display("FAIL bp_pre: got ch %0d data %h expected ch 2 data c2", oc4, od4); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4 = $urandom;
            #1;
            checks++; if (r4 !== 4'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, r4); end
            tick;
            checks++; if (ov4 !== 1'b1 || oc4 !== 2'd2 || od4 !== 8'hc2)
                begin fails++; $display("FAIL bp_hold[%0d]: got v %b ch %0d data %h expected v 1 ch 2 data c2", i, ov4, oc4, od4); end
        end
        d4 = 32'hd3c2b1a0; out_ready = 1'b1;
        #1;
        checks++; if (r4 !== 4'b1000) begin fails++; $display("FAIL bp_resume_ready: got %b expected 1000", r4); end
        tick;
        checks++; if (oc4 !== 2'd3 || od4 !== 8'hd3) begin fails++; $display("FAIL bp_resume1: got ch %0d data %h expected ch 3 data d3", oc4, od4); end
        tick;
        checks++; if (oc4 !== 2'd0 || od4 !== 8'ha0) begin fails++; $display("FAIL bp_resume2: got ch %0d data %h expected ch 0 data a0", oc4, od4); end
    endtask

    task automatic test_np2;
        pulse_reset;
        mode = 1'b1; out_ready = 1'b1; v3 = 3'b111; d3 = 24'h221100;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (ov3 !== 1'b1 || oc3 !== 2'(i % 3) || od3 !== 8'(17 * (i % 3)))
                begin fails++; $display("FAIL np2[%0d]: got v %b ch %0d data %h expected ch %0d", i, ov3, oc3, od3, i % 3); end
        end
        v3 = '0;
    endtask

    task automatic test_reset_mid;
        pulse_reset;
        mode = 1'b1; out_ready = 1'b1; v4 = 4'hf; d4 = 32'h03020100;
        tick; tick; tick;
        checks++; if (ov4 !== 1'b1 || oc4 !== 2'd2) begin fails++; $display("FAIL mid_pre: got v %b ch %0d expected v 1 ch 2", ov4, oc4); end
        rst = 1'b1;
        #1;
        checks++; if (r4 !== 4'b0) begin fails++; $display("FAIL mid_rst_ready: got %b expected 0000", r4); end
        tick;
        checks++; if (ov4 !== 1'b0 || oc4 !== 2'd0 || od4 !== 8'h00)
            begin fails++; $display("FAIL mid_rst_out: got v %b ch %0d data %h expected v 0 ch 0 data 00", ov4, oc4, od4); end
        rst = 1'b0;
        #1;
        checks++; if (r4 !== 4'b0001) begin fails++; $display("FAIL mid_post_ready: got %b expected 0001", r4); end
        tick;
        checks++; if (ov4 !== 1'b1 || oc4 !== 2'd0) begin fails++; $display("FAIL mid_post_grant: got v %b ch %0d expected v 1 ch 0", ov4, oc4); end
    endtask

    task automatic test_random;
        int m_ptr = 0;
        bit m_ov = 1'b0;
        logic [7:0] m_od = 8'h00;
        int m_oc = 0;
        pulse_reset;
        for (int n = 0; n < 400; n++) begin
            bit found = 1'b0;
            bit load;
            int g = 0;
            logic [3:0] exp_ready;
            mode = 1'($urandom_range(0, 1)); sel4 = 2'($urandom_range(0, 3));
            v4 = 4'($urandom); d4 = $urandom; out_ready = $urandom_range(0, 3) != 0;
            if (mode == 1'b0) begin
                found = v4[sel4];
                g = int'(sel4);
            end else begin
                for (int o = 0; o < 4; o++)
                    if (!found && v4[(m_ptr + o) % 4]) begin found = 1'b1; g = (m_ptr + o) % 4; end
            end
            load = !m_ov || out_ready;
            exp_ready = (found && load) ? 4'(1 << g) : 4'b0;
            #1;
            checks++; if (r4 !== exp_ready) begin fails++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, r4, exp_ready); end
            tick;
            if (load) begin
                m_ov = found;
                if (found) begin
                    m_od = d4[g * 8 +: 8];
                    m_oc = g;
                    if (mode) m_ptr = (g + 1) % 4;
                end
            end
            checks++; if (ov4 !== m_ov || od4 !== m_od || oc4 !== 2'(m_oc))
                begin fails++; $display("FAIL rand_out[%0d]: got v %b data %h ch %0d expected v %b data %h ch %0d", n, ov4, od4, oc4, m_ov, m_od, m_oc); end
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; out_ready = 1'b0;
        sel4 = '0; v4 = '0; d4 = '0;
        sel8 = '0; v8 = '0; d8 = '0;
        sel3 = '0; v3 = '0; d3 = '0;
        test_reset;
        test_manual;
        test_rr_fair;
        test_backpressure;
        test_np2;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel stream multiplexer, successor to the fixed 4:1 combinational mux. Each channel carries WIDTH-bit data with a valid/ready handshake. The block selects one channel per cycle, either by an explicit select or by round-robin arbitration, and drives a registered one-deep output stage. It sits between multiple producer streams and a single consumer.

Parameters:
N_CH, 4, number of input channels (>=2, need not be a power of 2)
WIDTH, 8, data width per channel
SEL_W, $clog2(N_CH), width of select and channel-ID fields (derived; not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = MANUAL (use sel), 1 = ROUND_ROBIN
sel  input  SEL_W  channel select, used in MANUAL mode only
in_valid  input  N_CH  per-channel valid
in_data  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  N_CH  per-channel ready, combinational, one-hot or zero
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered data
out_ch  output  SEL_W  channel ID of out_data
out_ready  input  1  consumer accepts the word when out_valid && out_ready

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all zeros while rst=1.
- load_en = !out_valid || out_ready. This gives full throughput of 1 word/cycle while out_ready is held high.
- Grant, combinational, evaluated every cycle:
  - MANUAL: grant is sel if sel<N_CH and in_valid[sel]; otherwise there is no grant.
  - ROUND_ROBIN: grant is the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, … and wrapping modulo N_CH. If no valid bit is set, there is no grant.
- in_ready[g]=1 only when a grant g exists and load_en=1. All other in_ready bits are 0.
- Transfer on the edge where a grant exists and load_en=1: out_data<=in_data[g], out_ch<=g, out_valid<=1.
- Edge with load_en=1 and no grant: out_valid<=0, and out_data/out_ch hold their previous values.
- When out_valid=1 and out_ready=0, the register holds. No channel sees in_ready, and out_data/out_ch are stable.
- Latency: a word accepted at edge k appears on out_* immediately after edge k, i.e. 1 cycle.
- rr_ptr updates only on a transfer in ROUND_ROBIN mode: rr_ptr<=(g==N_CH-1)?0:g+1. The wrap is explicit; it does not rely on power-of-2 overflow.
- MANUAL transfers leave rr_ptr unchanged.
- Mode changes take effect in the same cycle's grant logic. rr_ptr is retained across mode switches.
- sel>=N_CH in MANUAL mode produces no grant and no error flag. The output drains normally.
- Reset asserted mid-stream discards the held word. Nothing is transferred on the reset edge.
- No combinational path from out_ready to out_data. A combinational path from out_ready to in_ready is allowed.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_MANUAL=0, MODE_RR=1} mux_mode_e
  - helper function next_ptr(ptr, n) implementing the modulo-N wrap
- Sub-module rr_pick #(N_CH): inputs req[N_CH] and start[SEL_W]; outputs found and idx[SEL_W]. It is a rotating-priority encoder and is reusable by later arbiters.
- stream_mux_rr instantiates rr_pick and holds the output register and rr_ptr.

Test Plan:
1. Reset, then check idle behaviour. Hold rst for 2 cycles with all in_valid=1. Then: out_valid=0, out_data=0, out_ch=0, in_ready=0. After release with in_valid=0: out_valid stays 0.
2. MANUAL select. Set mode=0, sel=2, in_valid=4'b1111, ch0..3 data=8'h00/01/02/03, out_ready=1. Required: in_ready=4'b0100, and the next cycle shows out_data=8'h02, out_ch=2, out_valid=1. Then set sel=5 with N_CH=8 and in_valid[5]=0: out_valid drops to 0.
3. Round-robin fairness. Set mode=1, all 4 channels valid continuously, out_ready=1. Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles. With only ch1 and ch3 valid, starting from rr_ptr=2: sequence 3,1,3,1.
4. Backpressure. Run RR with all valid, then hold out_ready=0 for 3 cycles while out_valid=1. Required: out_data/out_ch constant, in_ready=0, rr_ptr frozen. When out_ready returns to 1, the next channel in order is granted and no word is lost or duplicated.
5. Non-power-of-2 wrap. Use N_CH=3, mode=1, all valid. Required: out_ch sequence 0,1,2,0,1,2. rr_ptr never reaches 3.
6. Reset mid-stream. Assert rst for 1 cycle while out_valid=1 with out_ch=2. Required: the next cycle shows out_valid=0 and rr_ptr=0. The first post-reset RR grant goes to ch0.
